// File: rtl/stopwatch_mode_ctrl.sv
// rtl/stopwatch_mode_ctrl.sv - front-panel sequencer for the stopwatch/timer counter
//
// Purpose: turns debounced button levels into counter control (enable,
// direction, adjust pulses, clear), runs the stopwatch / countdown FSM and
// raises an alarm on countdown expiry.
// Optional feature macro: STOPWATCH_LAP_HOLD_EN (lap freeze of disp_* in SW_RUN).
// Ports:
//   clk_high_speed, rst           clock, async active-high reset
//   tick_1khz                     1 kHz square wave (edge detected here)
//   btn_start/clear/mode/sec/min  debounced button levels
//   time_ms/sec/min               counter value
//   cnt_en, cnt_up_down           counter enable / direction
//   cnt_inc_sec, cnt_inc_min      adjust pulses
//   cnt_clr                       counter clear request
//   disp_ms/sec/min               registered display value
//   alarm, state                  expiry indicator, FSM state code
module stopwatch_mode_ctrl #(
    parameter int ALARM_MS = 3000,
    parameter int INC_HOLD = 4,
    parameter int CLR_HOLD = 2
) (
    input  logic       clk_high_speed,
    input  logic       rst,
    input  logic       tick_1khz,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic [9:0] time_ms,
    input  logic [5:0] time_sec,
    input  logic [5:0] time_min,
    output logic       cnt_en,
    output logic       cnt_up_down,
    output logic       cnt_inc_sec,
    output logic       cnt_inc_min,
    output logic       cnt_clr,
    output logic [9:0] disp_ms,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int PW = 8;
    localparam int AW = $clog2(ALARM_MS + 1);

    typedef enum logic [2:0] {
        SW_IDLE   = 3'd0,
        SW_RUN    = 3'd1,
        SW_PAUSE  = 3'd2,
        TMR_SET   = 3'd3,
        TMR_RUN   = 3'd4,
        TMR_PAUSE = 3'd5,
        TMR_DONE  = 3'd6
    } state_t;

    state_t          state_q;
    logic [4:0]      btn_prev_q;   // {min, sec, mode, clear, start}
    logic [4:0]      btn_edge_q;
    logic            tick_prev_q;
    logic            tick_edge_q;
    logic            zero_q;
    logic [PW-1:0]   hi_cnt_q;     // remaining high cycles of the active pulse
    logic [PW-1:0]   lo_cnt_q;     // remaining low-hold cycles after a pulse
    logic [PW-1:0]   lo_len_q;     // low-hold length to load when the pulse drops
    logic [AW-1:0]   alarm_cnt_q;
    logic            cnt_en_q, cnt_up_down_q, cnt_inc_sec_q, cnt_inc_min_q, cnt_clr_q;
    logic            alarm_q;
    logic [9:0]      disp_ms_q;
    logic [5:0]      disp_sec_q, disp_min_q;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic            lap_hold_q;
`endif

    logic act_start, act_clear, act_mode, act_sec, act_min, any_edge, busy;
    logic en_want, ud_want;

    // Only the highest-priority edge of a cycle survives.
    assign act_clear = btn_edge_q[1];
    assign act_start = btn_edge_q[0] & ~btn_edge_q[1];
    assign act_mode  = btn_edge_q[2] & ~(|btn_edge_q[1:0]);
    assign act_sec   = btn_edge_q[3] & ~(|btn_edge_q[2:0]);
    assign act_min   = btn_edge_q[4] & ~(|btn_edge_q[3:0]);
    assign any_edge  = |btn_edge_q;
    assign busy      = cnt_inc_sec_q | cnt_inc_min_q | cnt_clr_q | (lo_cnt_q != '0);

    // Direction per state; states that do not care keep the current value.
    always_comb begin
        ud_want = cnt_up_down_q;
        en_want = 1'b0;
        case (state_q)
            SW_IDLE, TMR_SET: ud_want = 1'b1;
            SW_RUN:  begin ud_want = 1'b1; en_want = 1'b1; end
            TMR_RUN: begin ud_want = 1'b0; en_want = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_high_speed or posedge rst) begin
        if (rst) begin
            state_q       <= SW_IDLE;
            btn_prev_q    <= '0;
            btn_edge_q    <= '0;
            tick_prev_q   <= 1'b0;
            tick_edge_q   <= 1'b0;
            zero_q        <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            lo_len_q      <= '0;
            alarm_cnt_q   <= '0;
            cnt_en_q      <= 1'b0;
            cnt_up_down_q <= 1'b0;
            cnt_inc_sec_q <= 1'b0;
            cnt_inc_min_q <= 1'b0;
            cnt_clr_q     <= 1'b0;
            alarm_q       <= 1'b0;
            disp_ms_q     <= '0;
            disp_sec_q    <= '0;
            disp_min_q    <= '0;
`ifdef STOPWATCH_LAP_HOLD_EN
            lap_hold_q    <= 1'b0;
`endif
        end else begin
            btn_prev_q  <= {btn_min, btn_sec, btn_mode, btn_clear, btn_start};
            btn_edge_q  <= {btn_min, btn_sec, btn_mode, btn_clear, btn_start} & ~btn_prev_q;
            tick_prev_q <= tick_1khz;
            tick_edge_q <= tick_1khz & ~tick_prev_q;
            zero_q      <= (time_ms == '0) && (time_sec == '0) && (time_min == '0);

`ifdef STOPWATCH_LAP_HOLD_EN
            if (!lap_hold_q) begin
`else
            begin
`endif
                disp_ms_q  <= time_ms;
                disp_sec_q <= time_sec;
                disp_min_q <= time_min;
            end

            // Pulse engine: high phase, then optional low hold; busy blocks new edges.
            if (hi_cnt_q != '0) begin
                hi_cnt_q <= hi_cnt_q - 1'b1;
            end else if (cnt_inc_sec_q | cnt_inc_min_q | cnt_clr_q) begin
                cnt_inc_sec_q <= 1'b0;
                cnt_inc_min_q <= 1'b0;
                cnt_clr_q     <= 1'b0;
                lo_cnt_q      <= lo_len_q;
            end else if (lo_cnt_q != '0) begin
                lo_cnt_q <= lo_cnt_q - 1'b1;
            end

            // Direction only moves while the counter is already stopped, and
            // enable only rises once the direction is settled.
            if (!cnt_en_q && (cnt_up_down_q != ud_want)) begin
                cnt_up_down_q <= ud_want;
                cnt_en_q      <= 1'b0;
            end else begin
                cnt_en_q <= en_want && (cnt_up_down_q == ud_want);
            end

            case (state_q)
                SW_IDLE: if (!busy) begin
                    if (act_start) state_q <= SW_RUN;
                    else if (act_clear) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                    end else if (act_mode) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                        state_q   <= TMR_SET;
                    end
                end
                SW_RUN: if (!busy) begin
                    if (act_start) begin
                        state_q  <= SW_PAUSE;
                        cnt_en_q <= 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
                        lap_hold_q <= 1'b0;
                    end else if (act_clear) begin
                        lap_hold_q <= ~lap_hold_q;
`endif
                    end
                end
                SW_PAUSE: if (!busy) begin
                    if (act_start) state_q <= SW_RUN;
                    else if (act_clear) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                        state_q   <= SW_IDLE;
`ifdef STOPWATCH_LAP_HOLD_EN
                        lap_hold_q <= 1'b0;
`endif
                    end
                end
                TMR_SET: if (!busy) begin
                    if (act_clear) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                    end else if (act_start) begin
                        if (!zero_q) state_q <= TMR_RUN;
                    end else if (act_mode) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                        state_q   <= SW_IDLE;
                    end else if (act_sec) begin
                        cnt_inc_sec_q <= 1'b1; hi_cnt_q <= PW'(INC_HOLD - 1);
                        lo_len_q      <= PW'(INC_HOLD - 1);
                    end else if (act_min) begin
                        cnt_inc_min_q <= 1'b1; hi_cnt_q <= PW'(INC_HOLD - 1);
                        lo_len_q      <= PW'(INC_HOLD - 1);
                    end
                end
                TMR_RUN: begin
                    if (zero_q) begin
                        state_q     <= TMR_DONE;
                        cnt_en_q    <= 1'b0;
                        alarm_q     <= 1'b1;
                        alarm_cnt_q <= '0;
                    end else if (!busy && act_start) begin
                        state_q  <= TMR_PAUSE;
                        cnt_en_q <= 1'b0;
                    end
                end
                TMR_PAUSE: if (!busy) begin
                    if (act_start) begin
                        if (!zero_q) state_q <= TMR_RUN;
                    end else if (act_clear) begin
                        cnt_clr_q <= 1'b1; hi_cnt_q <= PW'(CLR_HOLD - 1); lo_len_q <= '0;
                        state_q   <= TMR_SET;
                    end
                end
                TMR_DONE: begin
                    // Any button edge silences the alarm and is not acted on otherwise.
                    if (any_edge || (tick_edge_q && (alarm_cnt_q == AW'(ALARM_MS - 1)))) begin
                        alarm_q     <= 1'b0;
                        alarm_cnt_q <= '0;
                        state_q     <= TMR_SET;
                    end else if (tick_edge_q) begin
                        alarm_cnt_q <= alarm_cnt_q + 1'b1;
                    end
                end
                default: state_q <= SW_IDLE;
            endcase
        end
    end

    assign cnt_en      = cnt_en_q;
    assign cnt_up_down = cnt_up_down_q;
    assign cnt_inc_sec = cnt_inc_sec_q;
    assign cnt_inc_min = cnt_inc_min_q;
    assign cnt_clr     = cnt_clr_q;
    assign disp_ms     = disp_ms_q;
    assign disp_sec    = disp_sec_q;
    assign disp_min    = disp_min_q;
    assign alarm       = alarm_q;
    assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// tb/tb_stopwatch_mode_ctrl.sv - self-checking bench for stopwatch_mode_ctrl
module tb_stopwatch_mode_ctrl;

    typedef struct {
        int kind;   // 1 = inc_sec, 2 = inc_min, 3 = clr
        int width;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] btns = '0;   // {min, sec, mode, clear, start}
    logic [9:0] t_ms = '0;
    logic [5:0] t_sec = '0;
    logic [5:0] t_min = '0;

    logic       cnt_en, cnt_up_down, cnt_inc_sec, cnt_inc_min, cnt_clr, alarm;
    logic [9:0] disp_ms;
    logic [5:0] disp_sec, disp_min;
    logic [2:0] state;

    pulse_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     w_sec = 0, w_min = 0, w_clr = 0;
    int     alarm_ticks = 0;
    logic   tick_last = 1'b0;

    stopwatch_mode_ctrl dut (
        .clk_high_speed(clk),
        .rst(rst),
        .tick_1khz(tick),
        .btn_start(btns[0]),
        .btn_clear(btns[1]),
        .btn_mode(btns[2]),
        .btn_sec(btns[3]),
        .btn_min(btns[4]),
        .time_ms(t_ms),
        .time_sec(t_sec),
        .time_min(t_min),
        .cnt_en(cnt_en),
        .cnt_up_down(cnt_up_down),
        .cnt_inc_sec(cnt_inc_sec),
        .cnt_inc_min(cnt_inc_min),
        .cnt_clr(cnt_clr),
        .disp_ms(disp_ms),
        .disp_sec(disp_sec),
        .disp_min(disp_min),
        .alarm(alarm),
        .state(state)
    );

    always #5 clk = ~clk;

    always begin
        repeat (2) @(posedge clk);
        #1 tick = ~tick;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_pulse(input int kind, input int width);
        pulse_t e;
        e.kind  = kind;
        e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input int width);
        pulse_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_pulse", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_width", width, e.width);
        end
    endtask

    // Pulse monitor: measures each completed pulse and scores it against the queue.
    always @(negedge clk) begin
        if (rst) begin
            w_sec = 0; w_min = 0; w_clr = 0;
        end else begin
            if (cnt_inc_sec) w_sec++;
            else if (w_sec != 0) begin sb_pop(1, w_sec); w_sec = 0; end
            if (cnt_inc_min) w_min++;
            else if (w_min != 0) begin sb_pop(2, w_min); w_min = 0; end
            if (cnt_clr) w_clr++;
            else if (w_clr != 0) begin sb_pop(3, w_clr); w_clr = 0; end
        end
        if (alarm && tick && !tick_last) alarm_ticks++;
        tick_last = tick;
    end

    task automatic press(input logic [4:0] m);
        btns = m;
        repeat (4) @(negedge clk);
        btns = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", {29'd0, state}, 0);
        check("rst_en", cnt_en, 0);
        check("rst_ud", cnt_up_down, 0);
        check("rst_clr", cnt_clr, 0);
        check("rst_alarm", alarm, 0);
        check("rst_disp_ms", disp_ms, 0);
        rst = 1'b0;

        t_ms = 10'd123;
        repeat (3) @(negedge clk);
        check("disp_track", disp_ms, 123);

        press(5'b00001);
        wait_state(3'd1, 8, "sw_run");
        check("sw_run_en", cnt_en, 1);
        check("sw_run_ud", cnt_up_down, 1);

        press(5'b00001);
        wait_state(3'd2, 8, "sw_pause");
        check("sw_pause_en", cnt_en, 0);

        expect_pulse(3, 2);
        press(5'b00010);
        wait_state(3'd0, 8, "pause_clear_idle");

        expect_pulse(3, 2);
        press(5'b00100);
        wait_state(3'd3, 8, "mode_tmr_set");

        for (int i = 0; i < 3; i++) begin
            expect_pulse(1, 4);
            press(5'b01000);
        end
        expect_pulse(1, 4);
        press(5'b11000);
        repeat (5) @(negedge clk);
        check("sb_drained_inc", exp_q.size(), 0);

        t_ms = '0; t_sec = '0; t_min = '0;
        repeat (3) @(negedge clk);
        press(5'b00001);
        check("tmr_start_ignored_zero", {29'd0, state}, 3);

        t_sec = 6'd2;
        repeat (3) @(negedge clk);
        press(5'b00001);
        wait_state(3'd4, 8, "tmr_run");
        check("tmr_run_ud", cnt_up_down, 0);
        check("tmr_run_en", cnt_en, 1);

        alarm_ticks = 0;
        t_sec = '0;
        wait_state(3'd6, 10, "tmr_done");
        repeat (3) @(negedge clk);
        check("tmr_done_en", cnt_en, 0);
        check("tmr_done_alarm", alarm, 1);
        wait_state(3'd3, 13000, "alarm_expire_set");
        check("alarm_off", alarm, 0);
        check("alarm_tick_count", (alarm_ticks >= 2999 && alarm_ticks <= 3001), 1);
        if (alarm_ticks < 2999 || alarm_ticks > 3001)
            $display("alarm ticks observed %0d", alarm_ticks);

        t_sec = 6'd2;
        repeat (3) @(negedge clk);
        press(5'b00001);
        wait_state(3'd4, 8, "tmr_run2");
        t_sec = '0;
        wait_state(3'd6, 10, "tmr_done2");
        t_sec = 6'd5;
        repeat (3) @(negedge clk);
        btns = 5'b00001;
        wait_state(3'd3, 6, "done_start_exit");
        check("done_start_alarm_off", alarm, 0);
        repeat (4) @(negedge clk);
        btns = '0;
        repeat (12) @(negedge clk);
        check("done_start_consumed", {29'd0, state}, 3);

        expect_pulse(3, 2);
        press(5'b00100);
        wait_state(3'd0, 8, "tmr_set_mode_idle");

        t_ms = 10'd500;
        press(5'b00001);
        wait_state(3'd1, 8, "sw_run_lap");
`ifdef STOPWATCH_LAP_HOLD_EN
        press(5'b00010);
        t_ms = 10'd600;
        repeat (3) @(negedge clk);
        check("lap_freeze", disp_ms, 500);
        check("lap_state", {29'd0, state}, 1);
        press(5'b00010);
        t_ms = 10'd700;
        repeat (3) @(negedge clk);
        check("lap_release", disp_ms, 700);
`else
        press(5'b00010);
        check("sw_run_clear_ignored", {29'd0, state}, 1);
        t_ms = 10'd600;
        repeat (3) @(negedge clk);
        check("sw_run_disp_track", disp_ms, 600);
`endif

        press(5'b00001);
        wait_state(3'd2, 8, "sw_pause2");
        expect_pulse(3, 2);
        press(5'b00011);
        check("prio_clear_over_start", {29'd0, state}, 0);

        btns = 5'b00010;
        n = 0;
        while (!cnt_clr && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("clr_seen", cnt_clr, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_pulse_clr", cnt_clr, 0);
        check("rst_mid_pulse_state", {29'd0, state}, 0);
        btns = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
